sw_req_initiator: RTL and testbench

Host-side master for the software request/response interface of the secure data adaptor (top).
- Request side: takes one command (data type plus key hash), serializes it into the 4-flit request (req_valid/data_in), then collects the multi-flit response (rsp_valid/data_out) while driving rd_ready.
- Used by system-level benches and by the host bridge in place of hand-written flit sequences.

---
 rtl/sw_if_pkg.sv | 23 ++
 rtl/sw_rsp_collector.sv | 64 ++++++
 rtl/sw_req_initiator.sv | 143 ++++++++++++++
 tb/tb_sw_req_initiator.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sw_if_pkg.sv
// Shared definitions for the software request/response interface,
// used by the host-side initiator and the target-side adaptor.
package sw_if_pkg;

    localparam int unsigned DEF_PKT_S       = 32;
    localparam int unsigned DEF_DT_S        = 3;
    localparam int unsigned DEF_KH_S        = 64;
    localparam int unsigned DEF_D_S         = 128;
    localparam int unsigned DEF_RSP_TIMEOUT = 64;

    localparam logic [1:0] FLIT_HDR    = 2'd0;
    localparam logic [1:0] FLIT_TYPE   = 2'd1;
    localparam logic [1:0] FLIT_KEY_HI = 2'd2;
    localparam logic [1:0] FLIT_KEY_LO = 2'd3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        WAIT_RSP = 2'd2,
        DONE     = 2'd3
    } sw_state_e;

endpackage

// File: rtl/sw_rsp_collector.sv
// Response side of the initiator: assembles response flits MSB-first and
// tracks the per-request timeout while the top-level FSM is in WAIT_RSP.
module sw_rsp_collector
    import sw_if_pkg::*;
#(
    parameter int unsigned PKT_S       = DEF_PKT_S,
    parameter int unsigned D_S         = DEF_D_S,
    parameter int unsigned RSP_TIMEOUT = DEF_RSP_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             active,
    input  logic             rsp_valid,
    input  logic [PKT_S-1:0] rsp_data,
    output logic [D_S-1:0]   data,
    output logic             last,
    output logic             timed_out
);

    localparam int unsigned NFLIT = D_S / PKT_S;
    localparam int unsigned CNT_W = $clog2(NFLIT + 1);
    localparam int unsigned TMO_W = $clog2(RSP_TIMEOUT + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NFLIT - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RSP_TIMEOUT - 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(RSP_TIMEOUT);

    logic [CNT_W-1:0] rsp_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic             take;

    assign take      = active & rsp_valid;
    assign last      = take & (rsp_cnt == CNT_LAST);
    // A final flit arriving on the timeout cycle still completes the response.
    assign timed_out = active & (tmo_cnt == TMO_LAST) & ~last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data    <= '0;
            rsp_cnt <= '0;
            tmo_cnt <= '0;
        end else if (clear) begin
            data    <= '0;
            rsp_cnt <= '0;
            tmo_cnt <= '0;
        end else if (active) begin
            if (tmo_cnt != TMO_MAX) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
            if (take) begin
                rsp_cnt <= rsp_cnt + CNT_W'(1);
                // Slot-indexed write: flit k lands in the k-th slot from the top,
                // so a partial (timed-out) response is already MSB-aligned.
                for (int unsigned i = 0; i < NFLIT; i++) begin
                    if (rsp_cnt == CNT_W'(i)) begin
                        data[(NFLIT-1-i)*PKT_S +: PKT_S] <= rsp_data;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/sw_req_initiator.sv
// Host-side master: serializes one command into the 4-flit request, then
// collects the multi-flit response (or a timeout) and hands it to the consumer.
module sw_req_initiator
    import sw_if_pkg::*;
#(
    parameter int unsigned PKT_S       = DEF_PKT_S,
    parameter int unsigned DT_S        = DEF_DT_S,
    parameter int unsigned KH_S        = DEF_KH_S,
    parameter int unsigned D_S         = DEF_D_S,
    parameter int unsigned RSP_TIMEOUT = DEF_RSP_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [DT_S-1:0]  cmd_type,
    input  logic [KH_S-1:0]  cmd_key,
    output logic [PKT_S-1:0] req_data,
    output logic             req_valid,
    input  logic [PKT_S-1:0] rsp_data,
    input  logic             rsp_valid,
    output logic             rd_ready,
    output logic [D_S-1:0]   resp_data,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_timeout,
    output logic             busy
);

    if (KH_S != 2 * PKT_S) begin : g_chk_kh
        $error("sw_req_initiator: KH_S must equal 2*PKT_S");
    end
    if (D_S % PKT_S != 0) begin : g_chk_d
        $error("sw_req_initiator: D_S must be a multiple of PKT_S");
    end
    if (DT_S > PKT_S) begin : g_chk_dt
        $error("sw_req_initiator: DT_S must not exceed PKT_S");
    end
    if (RSP_TIMEOUT < 1) begin : g_chk_tmo
        $error("sw_req_initiator: RSP_TIMEOUT must be at least 1");
    end

    sw_state_e       state;
    logic [1:0]      flit_idx;
    logic [DT_S-1:0] type_q;
    logic [KH_S-1:0] key_q;
    logic            accept;
    logic            rsp_last;
    logic            rsp_tmo;

    assign cmd_ready = (state == IDLE);
    assign accept    = cmd_valid & cmd_ready;

    function automatic logic [PKT_S-1:0] flit_sel(
        input logic [1:0]      idx,
        input logic [DT_S-1:0] t,
        input logic [KH_S-1:0] k
    );
        logic [PKT_S-1:0] f;
        f = '0;
        case (idx)
            FLIT_TYPE:   f = PKT_S'(t);
            FLIT_KEY_HI: f = k[KH_S-1:PKT_S];
            FLIT_KEY_LO: f = k[PKT_S-1:0];
            default:     f = '0;
        endcase
        return f;
    endfunction

    sw_rsp_collector #(
        .PKT_S      (PKT_S),
        .D_S        (D_S),
        .RSP_TIMEOUT(RSP_TIMEOUT)
    ) u_collector (
        .clk      (clk),
        .rst      (rst),
        .clear    (accept),
        .active   (state == WAIT_RSP),
        .rsp_valid(rsp_valid),
        .rsp_data (rsp_data),
        .data     (resp_data),
        .last     (rsp_last),
        .timed_out(rsp_tmo)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            flit_idx     <= '0;
            type_q       <= '0;
            key_q        <= '0;
            req_valid    <= 1'b0;
            req_data     <= '0;
            rd_ready     <= 1'b0;
            resp_valid   <= 1'b0;
            resp_timeout <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        type_q    <= cmd_type;
                        key_q     <= cmd_key;
                        flit_idx  <= FLIT_HDR;
                        req_valid <= 1'b1;
                        req_data  <= flit_sel(FLIT_HDR, cmd_type, cmd_key);
                        busy      <= 1'b1;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (flit_idx == FLIT_KEY_LO) begin
                        req_valid <= 1'b0;
                        req_data  <= '0;
                        rd_ready  <= 1'b1;
                        state     <= WAIT_RSP;
                    end else begin
                        flit_idx <= flit_idx + 2'd1;
                        req_data <= flit_sel(flit_idx + 2'd1, type_q, key_q);
                    end
                end
                WAIT_RSP: begin
                    if (rsp_last || rsp_tmo) begin
                        rd_ready     <= 1'b0;
                        resp_valid   <= 1'b1;
                        resp_timeout <= rsp_tmo;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    if (resp_ready) begin
                        resp_valid   <= 1'b0;
                        resp_timeout <= 1'b0;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sw_req_initiator.sv
// Randomized self-checking bench for sw_req_initiator against a
// transaction-level model of the request/response protocol.
module tb_sw_req_initiator;

    localparam int PKT_S       = 32;
    localparam int DT_S        = 3;
    localparam int KH_S        = 64;
    localparam int D_S         = 128;
    localparam int RSP_TIMEOUT = 8;
    localparam int NFLIT       = D_S / PKT_S;

    typedef logic [D_S-1:0] wide_t;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [DT_S-1:0]  cmd_type;
    logic [KH_S-1:0]  cmd_key;
    logic [PKT_S-1:0] req_data;
    logic             req_valid;
    logic [PKT_S-1:0] rsp_data;
    logic             rsp_valid;
    logic             rd_ready;
    logic [D_S-1:0]   resp_data;
    logic             resp_valid;
    logic             resp_ready;
    logic             resp_timeout;
    logic             busy;

    int n_cmp;
    int n_bad;

    logic             sv [RSP_TIMEOUT];
    logic [PKT_S-1:0] sd [RSP_TIMEOUT];

    sw_req_initiator #(
        .PKT_S      (PKT_S),
        .DT_S       (DT_S),
        .KH_S       (KH_S),
        .D_S        (D_S),
        .RSP_TIMEOUT(RSP_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_type    (cmd_type),
        .cmd_key     (cmd_key),
        .req_data    (req_data),
        .req_valid   (req_valid),
        .rsp_data    (rsp_data),
        .rsp_valid   (rsp_valid),
        .rd_ready    (rd_ready),
        .resp_data   (resp_data),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_timeout(resp_timeout),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input wide_t got, input wide_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic fill_random();
        int pct;
        pct = int'($urandom_range(30, 95));
        for (int j = 0; j < RSP_TIMEOUT; j++) begin
            sv[j] = (int'($urandom_range(0, 99)) < pct);
            sd[j] = $urandom;
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic run_txn(input logic [DT_S-1:0] t, input logic [KH_S-1:0] k,
                           input bit keep, input logic [DT_S-1:0] nt,
                           input logic [KH_S-1:0] nk, input int hold);
        logic [PKT_S-1:0] flits[$];
        logic [PKT_S-1:0] got_q[$];
        wide_t            exp_data;
        bit               exp_tmo;
        int               fin;
        wide_t            held;

        flits = {PKT_S'(0), PKT_S'(t), k[KH_S-1:PKT_S], k[PKT_S-1:0]};

        // Response model: flits offered inside the window are taken in order
        fin     = RSP_TIMEOUT - 1;
        exp_tmo = 1'b1;
        for (int j = 0; j < RSP_TIMEOUT; j++) begin
            if (sv[j]) begin
                got_q.push_back(sd[j]);
                if (got_q.size() == NFLIT) begin
                    fin     = j;
                    exp_tmo = 1'b0;
                    break;
                end
            end
        end
        exp_data = '0;
        foreach (got_q[i]) exp_data |= wide_t'(got_q[i]) << (D_S - PKT_S * (i + 1));

        check_eq("cmd_ready_idle", wide_t'(cmd_ready), wide_t'(1));
        cmd_valid = 1'b1;
        cmd_type  = t;
        cmd_key   = k;
        @(negedge clk);
        if (keep) begin
            cmd_type = nt;
            cmd_key  = nk;
        end else begin
            cmd_valid = 1'b0;
        end

        for (int i = 0; i < 4; i++) begin
            check_eq("req_valid", wide_t'(req_valid), wide_t'(1));
            check_eq("req_data", wide_t'(req_data), wide_t'(flits[i]));
            check_eq("cmd_ready_send", wide_t'(cmd_ready), wide_t'(0));
            @(negedge clk);
        end
        check_eq("req_valid_after", wide_t'(req_valid), wide_t'(0));
        check_eq("req_data_after", wide_t'(req_data), wide_t'(0));

        for (int j = 0; j <= fin; j++) begin
            check_eq("rd_ready_wait", wide_t'(rd_ready), wide_t'(1));
            check_eq("resp_valid_wait", wide_t'(resp_valid), wide_t'(0));
            rsp_valid = sv[j];
            rsp_data  = sv[j] ? sd[j] : PKT_S'($urandom);
            @(negedge clk);
        end
        rsp_valid = 1'b0;

        check_eq("resp_valid", wide_t'(resp_valid), wide_t'(1));
        check_eq("resp_timeout", wide_t'(resp_timeout), wide_t'(exp_tmo));
        check_eq("resp_data", resp_data, exp_data);
        check_eq("rd_ready_done", wide_t'(rd_ready), wide_t'(0));
        check_eq("busy_done", wide_t'(busy), wide_t'(1));
        held = resp_data;

        for (int h = 0; h < hold; h++) begin
            resp_ready = 1'b0;
            rsp_valid  = 1'($urandom_range(0, 1));
            rsp_data   = $urandom;
            @(negedge clk);
            check_eq("hold_valid", wide_t'(resp_valid), wide_t'(1));
            check_eq("hold_data", resp_data, held);
            check_eq("hold_cmd_ready", wide_t'(cmd_ready), wide_t'(0));
            check_eq("hold_rd_ready", wide_t'(rd_ready), wide_t'(0));
        end

        resp_ready = 1'b1;
        rsp_valid  = 1'($urandom_range(0, 1));
        rsp_data   = $urandom;
        @(negedge clk);
        resp_ready = 1'b0;
        rsp_valid  = 1'b0;
        check_eq("release_valid", wide_t'(resp_valid), wide_t'(0));
        check_eq("release_cmd_ready", wide_t'(cmd_ready), wide_t'(1));
        check_eq("release_busy", wide_t'(busy), wide_t'(0));
    endtask

    initial begin
        logic [DT_S-1:0] t1, t2;
        logic [KH_S-1:0] k1, k2;

        n_cmp      = 0;
        n_bad      = 0;
        rst        = 1'b0;
        cmd_valid  = 1'b0;
        cmd_type   = '0;
        cmd_key    = '0;
        rsp_valid  = 1'b0;
        rsp_data   = '0;
        resp_ready = 1'b0;

        repeat (3) @(negedge clk);
        check_eq("rst_req_valid", wide_t'(req_valid), wide_t'(0));
        check_eq("rst_req_data", wide_t'(req_data), wide_t'(0));
        check_eq("rst_rd_ready", wide_t'(rd_ready), wide_t'(0));
        check_eq("rst_resp_valid", wide_t'(resp_valid), wide_t'(0));
        check_eq("rst_resp_data", resp_data, wide_t'(0));
        check_eq("rst_busy", wide_t'(busy), wide_t'(0));
        rst = 1'b1;
        @(negedge clk);

        // Privileged request with a gapped 4-flit response
        for (int j = 0; j < RSP_TIMEOUT; j++) begin
            sv[j] = 1'b0;
            sd[j] = '0;
        end
        sv[0] = 1'b1; sd[0] = 32'h11111111;
        sv[1] = 1'b1; sd[1] = 32'h22222222;
        sv[4] = 1'b1; sd[4] = 32'h33333333;
        sv[5] = 1'b1; sd[5] = 32'h44444444;
        run_txn(3'd2, 64'hDEADBEEF_ABCDABCD, 1'b0, '0, '0, 1);

        // Timeout with a single flit, then result backpressure
        for (int j = 0; j < RSP_TIMEOUT; j++) begin
            sv[j] = 1'b0;
            sd[j] = '0;
        end
        sv[0] = 1'b1; sd[0] = 32'hAAAAAAAA;
        run_txn(3'd5, {$urandom, $urandom}, 1'b0, '0, '0, 5);

        // Asynchronous reset while flit2 is on the wire
        cmd_valid = 1'b1;
        cmd_type  = 3'd7;
        cmd_key   = {$urandom, $urandom};
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("arst_req_valid", wide_t'(req_valid), wide_t'(0));
        check_eq("arst_req_data", wide_t'(req_data), wide_t'(0));
        check_eq("arst_busy", wide_t'(busy), wide_t'(0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("post_rst_busy", wide_t'(busy), wide_t'(0));
        check_eq("post_rst_cmd_ready", wide_t'(cmd_ready), wide_t'(1));
        fill_random();
        run_txn(DT_S'($urandom), {$urandom, $urandom}, 1'b0, '0, '0, 0);

        // Back-to-back commands with cmd_valid held high
        t1 = DT_S'($urandom); k1 = {$urandom, $urandom};
        t2 = DT_S'($urandom); k2 = {$urandom, $urandom};
        fill_random();
        run_txn(t1, k1, 1'b1, t2, k2, 2);
        fill_random();
        run_txn(t2, k2, 1'b0, '0, '0, 0);

        for (int n = 0; n < 40; n++) begin
            fill_random();
            run_txn(DT_S'($urandom), {$urandom, $urandom}, 1'b0, '0, '0,
                    int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
